// File: rtl/classifier_bin_loader_if.sv
// classifier_bin_loader_if: sample stream, window config and frame presentation bundle
interface classifier_bin_loader_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8,
  parameter int IDX_W     = $clog2(N_SAMPLES)
);
  logic signed [BIT_WIDTH-1:0]           recv_msg;
  logic                                  recv_val;
  logic                                  recv_rdy;
  logic [IDX_W-1:0]                      cfg_lo_bin;
  logic [IDX_W-1:0]                      cfg_hi_bin;
  logic [N_SAMPLES-1:0]                  filtered_valid;
  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0]   mag_out;
  logic                                  frame_val;
  logic                                  frame_ack;
  modport master (
    output recv_msg, recv_val, cfg_lo_bin, cfg_hi_bin, frame_ack,
    input  recv_rdy, filtered_valid, mag_out, frame_val
  );
  modport slave (
    input  recv_msg, recv_val, cfg_lo_bin, cfg_hi_bin, frame_ack,
    output recv_rdy, filtered_valid, mag_out, frame_val
  );
endinterface

// File: rtl/classifier_bin_loader.sv
// classifier_bin_loader: collects a frame of bin magnitudes with in-band flags for the comparator
module classifier_bin_loader #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8,
  parameter int IDX_W      = $clog2(N_SAMPLES)
) (
  input logic                    clk,
  input logic                    reset,
  classifier_bin_loader_if.slave bus
);
  typedef enum logic {LOAD, PRESENT} state_t;
  localparam logic [IDX_W-1:0]     LAST    = IDX_W'(N_SAMPLES - 1);
  localparam logic [BIT_WIDTH-1:0] MOST_NEG = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [BIT_WIDTH-1:0] MOST_POS = ~MOST_NEG;
  if (N_SAMPLES < 2 || DECIMAL_PT >= BIT_WIDTH) begin : g_bad_params
    $error("classifier_bin_loader: unsupported parameters");
  end
  state_t               state, state_n;
  logic [IDX_W-1:0]     cnt, lo_q, hi_q, lo, hi;
  logic [BIT_WIDTH-1:0] mag;
  logic                 fire;
  assign bus.recv_rdy  = (state == LOAD) && !reset;
  assign bus.frame_val = (state == PRESENT);
  // handshake, effective window (live cfg for bin 0), saturating magnitude, next state
  always_comb begin
    fire    = bus.recv_val && (state == LOAD);
    lo      = (cnt == '0) ? bus.cfg_lo_bin : lo_q;
    hi      = (cnt == '0) ? bus.cfg_hi_bin : hi_q;
    mag     = !bus.recv_msg[BIT_WIDTH-1] ? bus.recv_msg :
              (bus.recv_msg == MOST_NEG) ? MOST_POS : -bus.recv_msg;
    state_n = (state == LOAD) ? ((fire && cnt == LAST) ? PRESENT : LOAD) :
              (bus.frame_ack ? LOAD : PRESENT);
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_n;
  end
  // bin write, config latch on bin 0, flag clear on acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt                <= '0;
      lo_q               <= '0;
      hi_q               <= '0;
      bus.filtered_valid <= '0;
      bus.mag_out        <= '0;
    end else begin
      if (fire) begin
        bus.mag_out[cnt]        <= mag;
        bus.filtered_valid[cnt] <= (cnt >= lo) && (cnt <= hi);
        cnt                     <= (cnt == LAST) ? '0 : cnt + 1'b1;
        if (cnt == '0) begin
          lo_q <= bus.cfg_lo_bin;
          hi_q <= bus.cfg_hi_bin;
        end
      end
      if (state == PRESENT && bus.frame_ack) bus.filtered_valid <= '0;
    end
  end
endmodule

// File: tb/tb_classifier_bin_loader.sv
// tb_classifier_bin_loader: randomized scenarios against a frame-level reference model
module tb_classifier_bin_loader;
  localparam int BW = 32;
  localparam int N  = 8;
  localparam int IW = 3;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  classifier_bin_loader_if #(.BIT_WIDTH(BW), .N_SAMPLES(N), .IDX_W(IW)) bus();
  classifier_bin_loader #(.BIT_WIDTH(BW), .DECIMAL_PT(16), .N_SAMPLES(N), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );
  int checks = 0;
  int errors = 0;
  logic [BW-1:0]         smp [N];
  logic [N-1:0][BW-1:0]  exp_mag;
  logic [N-1:0]          exp_fv;

  function automatic logic [BW-1:0] ref_mag(input logic [BW-1:0] s);
    longint v;
    v = longint'($signed(s));
    if (v < 0) v = -v;
    if (v > 64'sh7fffffff) v = 64'sh7fffffff;
    return v[BW-1:0];
  endfunction

  function automatic void build_expected(input int lo, input int hi);
    for (int i = 0; i < N; i++) begin
      exp_mag[i] = ref_mag(smp[i]);
      exp_fv[i]  = (i >= lo) && (i <= hi);
    end
  endfunction

  function automatic logic [BW-1:0] rand_sample();
    case ($urandom_range(0, 3))
      0:       return 32'h8000_0000;
      1:       return 32'($signed($urandom_range(0, 400)) - 200);
      default: return $urandom;
    endcase
  endfunction

  task automatic load_frame(input int lo, input int hi, input bit mid, input int mlo,
                            input int mhi, input bit gaps);
    bus.cfg_lo_bin = IW'(lo);
    bus.cfg_hi_bin = IW'(hi);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.recv_val  = 1'b0;
          bus.frame_ack = 1'($urandom_range(0, 1));
          @(negedge clk);
        end
      end
      bus.frame_ack = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.recv_msg  = smp[i];
      bus.recv_val  = 1'b1;
      if (mid && i == 1) begin
        bus.cfg_lo_bin = IW'(mlo);
        bus.cfg_hi_bin = IW'(mhi);
      end
      checks++;
      if (bus.recv_rdy !== 1'b1 || bus.frame_val !== 1'b0) begin
        errors++;
        $display("FAIL load_bin%0d: rdy=%b frame_val=%b expected rdy=1 frame_val=0", i, bus.recv_rdy, bus.frame_val);
      end
      @(negedge clk);
    end
    bus.frame_ack = 1'b0;
  endtask

  task automatic do_ack();
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
    bus.recv_val  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.recv_val = 1'b0;
    bus.frame_ack = 1'b0;
    bus.recv_msg = '0;
    bus.cfg_lo_bin = '0;
    bus.cfg_hi_bin = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.recv_rdy !== 1'b0 || bus.frame_val !== 1'b0 || bus.filtered_valid !== '0 || bus.mag_out !== '0) begin
      errors++;
      $display("FAIL reset_values: rdy=%b fv=%b flags=%b mag=%h expected all zero", bus.recv_rdy, bus.frame_val, bus.filtered_valid, bus.mag_out);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.recv_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy: got %b expected 1", bus.recv_rdy);
    end
  endtask

  task automatic test_basic();
    logic [BW-1:0] vals [N] = '{32'd5, -32'sd7, 32'd20, -32'sd21, 32'd0, 32'd30, -32'sd1, 32'd100};
    logic [BW-1:0] mags [N] = '{32'd5, 32'd7, 32'd20, 32'd21, 32'd0, 32'd30, 32'd1, 32'd100};
    for (int i = 0; i < N; i++) begin
      smp[i]     = vals[i];
      exp_mag[i] = mags[i];
    end
    exp_fv = 8'b0011_1100;
    load_frame(2, 5, 0, 0, 0, 0);
    checks++;
    if (bus.frame_val !== 1'b1 || bus.recv_rdy !== 1'b0) begin
      errors++;
      $display("FAIL basic_present: frame_val=%b rdy=%b expected 1 0", bus.frame_val, bus.recv_rdy);
    end
    checks++;
    if (bus.mag_out !== exp_mag) begin
      errors++;
      $display("FAIL basic_mag: got %h expected %h", bus.mag_out, exp_mag);
    end
    checks++;
    if (bus.filtered_valid !== exp_fv) begin
      errors++;
      $display("FAIL basic_flags: got %b expected %b", bus.filtered_valid, exp_fv);
    end
  endtask

  task automatic test_hold();
    bus.recv_val = 1'b1;
    bus.recv_msg = 32'hDEAD_BEEF;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (bus.frame_val !== 1'b1 || bus.recv_rdy !== 1'b0 || bus.mag_out !== exp_mag || bus.filtered_valid !== exp_fv) begin
        errors++;
        $display("FAIL hold_cycle%0d: fv=%b rdy=%b flags=%b mag=%h expected 1 0 %b %h", c, bus.frame_val, bus.recv_rdy, bus.filtered_valid, bus.mag_out, exp_fv, exp_mag);
      end
    end
    do_ack();
    checks++;
    if (bus.frame_val !== 1'b0 || bus.recv_rdy !== 1'b1 || bus.filtered_valid !== '0) begin
      errors++;
      $display("FAIL ack_release: fv=%b rdy=%b flags=%b expected 0 1 0", bus.frame_val, bus.recv_rdy, bus.filtered_valid);
    end
    checks++;
    if (bus.mag_out !== exp_mag) begin
      errors++;
      $display("FAIL ack_mag_retained: got %h expected %h", bus.mag_out, exp_mag);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < N; i++) smp[i] = rand_sample();
    smp[3] = 32'h8000_0000;
    build_expected(0, 7);
    load_frame(0, 7, 0, 0, 0, 0);
    checks++;
    if (bus.mag_out[3] !== 32'h7FFF_FFFF || bus.filtered_valid !== 8'hFF) begin
      errors++;
      $display("FAIL saturate: mag3=%h flags=%b expected 7fffffff 11111111", bus.mag_out[3], bus.filtered_valid);
    end
    checks++;
    if (bus.mag_out !== exp_mag) begin
      errors++;
      $display("FAIL saturate_mag: got %h expected %h", bus.mag_out, exp_mag);
    end
    do_ack();
  endtask

  task automatic test_cfg_latch();
    for (int i = 0; i < N; i++) smp[i] = rand_sample();
    build_expected(1, 6);
    load_frame(1, 6, 1, 6, 1, 0);
    checks++;
    if (bus.filtered_valid !== 8'b0111_1110 || bus.mag_out !== exp_mag) begin
      errors++;
      $display("FAIL cfg_latched: flags=%b mag=%h expected 01111110 %h", bus.filtered_valid, bus.mag_out, exp_mag);
    end
    do_ack();
    for (int i = 0; i < N; i++) smp[i] = rand_sample();
    build_expected(6, 1);
    load_frame(6, 1, 0, 0, 0, 0);
    checks++;
    if (bus.filtered_valid !== 8'h00 || bus.mag_out !== exp_mag) begin
      errors++;
      $display("FAIL cfg_inverted: flags=%b mag=%h expected 00000000 %h", bus.filtered_valid, bus.mag_out, exp_mag);
    end
    do_ack();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      bus.recv_msg = rand_sample();
      bus.recv_val = 1'b1;
      @(negedge clk);
    end
    reset = 1'b1;
    bus.recv_val = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.recv_rdy !== 1'b0 || bus.frame_val !== 1'b0 || bus.filtered_valid !== '0 || bus.mag_out !== '0) begin
      errors++;
      $display("FAIL midreset_values: rdy=%b fv=%b flags=%b mag=%h expected all zero", bus.recv_rdy, bus.frame_val, bus.filtered_valid, bus.mag_out);
    end
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) smp[i] = rand_sample();
    build_expected(0, 3);
    load_frame(0, 3, 0, 0, 0, 0);
    checks++;
    if (bus.frame_val !== 1'b1 || bus.mag_out !== exp_mag || bus.filtered_valid !== exp_fv) begin
      errors++;
      $display("FAIL midreset_frame: fv=%b flags=%b mag=%h expected 1 %b %h", bus.frame_val, bus.filtered_valid, bus.mag_out, exp_fv, exp_mag);
    end
    do_ack();
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 6; f++) begin
      int lo = $urandom_range(0, 7);
      int hi = $urandom_range(0, 7);
      for (int i = 0; i < N; i++) smp[i] = rand_sample();
      build_expected(lo, hi);
      load_frame(lo, hi, 1, $urandom_range(0, 7), $urandom_range(0, 7), 1);
      bus.recv_val = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      checks++;
      if (bus.frame_val !== 1'b1 || bus.mag_out !== exp_mag || bus.filtered_valid !== exp_fv) begin
        errors++;
        $display("FAIL random_frame%0d lo=%0d hi=%0d: fv=%b flags=%b mag=%h expected 1 %b %h", f, lo, hi, bus.frame_val, bus.filtered_valid, bus.mag_out, exp_fv, exp_mag);
      end
      do_ack();
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] q [$];
    logic [BW-1:0] cur = '0;
    bit take = 1'b1;
    bit prev = 1'b0;
    int rise = -1;
    int frames = 0;
    int lo = $urandom_range(0, 7);
    int hi = $urandom_range(0, 7);
    bus.cfg_lo_bin = IW'(lo);
    bus.cfg_hi_bin = IW'(hi);
    bus.frame_ack  = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (bus.frame_val) begin
        checks++;
        if (prev) begin
          errors++;
          $display("FAIL b2b_pulse_width: frame_val high on consecutive cycles at %0d", c);
        end
        if (rise >= 0) begin
          checks++;
          if (c - rise != 9) begin
            errors++;
            $display("FAIL b2b_period: got %0d expected 9", c - rise);
          end
        end
        rise = c;
        frames++;
        checks++;
        if (q.size() != 8 * frames) begin
          errors++;
          $display("FAIL b2b_consumed: got %0d expected %0d", q.size(), 8 * frames);
        end else begin
          for (int i = 0; i < N; i++) smp[i] = q[(frames - 1) * 8 + i];
          build_expected(lo, hi);
          checks++;
          if (bus.mag_out !== exp_mag || bus.filtered_valid !== exp_fv) begin
            errors++;
            $display("FAIL b2b_frame%0d: flags=%b mag=%h expected %b %h", frames, bus.filtered_valid, bus.mag_out, exp_fv, exp_mag);
          end
        end
      end
      prev = bus.frame_val;
      if (take) cur = rand_sample();
      bus.recv_msg = cur;
      bus.recv_val = 1'b1;
      take = bus.recv_rdy;
      if (take) q.push_back(cur);
      @(negedge clk);
    end
    checks++;
    if (frames != 5) begin
      errors++;
      $display("FAIL b2b_frame_count: got %0d expected 5", frames);
    end
    bus.frame_ack = 1'b0;
    bus.recv_val  = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_saturate();
    test_cfg_latch();
    test_mid_reset();
    test_random_frames();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
